// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues sequential word fetches, buffers PC-tagged responses
// in a small FIFO and hands them to the decoder; redirects flush and drop stale words.
module ifetch_queue #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter int          DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = CW + 2;
  localparam logic [SW-1:0] DEPTH_W = SW'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   q_data [DEPTH];
  logic [31:0]   q_pc   [DEPTH];

  logic [SW-1:0] credit_sum;
  logic          fire;
  logic          pop;
  logic          rsp_live;
  logic          rsp_drop;
  logic          redirect_lsb_unused;

  assign credit_sum  = SW'(count) + SW'(outstanding) + SW'(discard);
  // Gated by rst_n so the request line is quiet while reset is held.
  assign req_valid   = rst_n && !redirect_valid && (credit_sum < DEPTH_W);
  assign req_addr    = fetch_pc;
  assign fire        = req_valid && req_ready;

  assign instr_valid = (count != '0) && !redirect_valid;
  assign instr_data  = q_data[rd_ptr];
  assign instr_pc    = q_pc[rd_ptr];
  assign pop         = instr_valid && instr_ready;

  assign rsp_live    = rsp_valid && (discard == '0);
  assign rsp_drop    = rsp_valid && (discard != '0);
  assign busy        = (outstanding != '0) || (discard != '0);

  assign redirect_lsb_unused = ^redirect_pc[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= PC_INIT;
      rsp_pc      <= PC_INIT;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_data[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else if (redirect_valid) begin
      // Everything in flight becomes stale; a response arriving now is consumed here.
      fetch_pc    <= {redirect_pc[31:2], 2'b00};
      rsp_pc      <= {redirect_pc[31:2], 2'b00};
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
      discard     <= discard + outstanding - CW'(rsp_valid);
    end else begin
      if (fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (rsp_live) begin
        q_data[wr_ptr] <= rsp_data;
        q_pc[wr_ptr]   <= rsp_pc;
        wr_ptr         <= wr_ptr + 1'b1;
        rsp_pc         <= rsp_pc + 32'd4;
      end
      if (rsp_drop) begin
        discard <= discard - 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count       <= count + CW'(rsp_live) - CW'(pop);
      outstanding <= outstanding + CW'(fire) - CW'(rsp_live);
    end
  end

  a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
    count <= CW'(DEPTH));
  a_credit_bound : assert property (@(posedge clk) disable iff (!rst_n)
    credit_sum <= DEPTH_W);

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: epoch-tagged memory/queue model, per-cycle compare plus
// directed scenarios (backpressure, redirects, PC wrap, mid-stream reset) and a random run.
module tb_ifetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] PC_INIT = 32'h8000_0000;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  ifetch_queue #(.PC_INIT(PC_INIT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int epoch; } flight_t;
  typedef struct { logic [31:0] data; logic [31:0] pc; } ent_t;

  flight_t     mem_q[$];   // requests accepted by memory, oldest first
  ent_t        fifo[$];    // expected queue contents
  int          epoch;
  logic [31:0] m_fetch_pc;
  logic [31:0] fire_log[$];
  ent_t        pop_log[$];

  int checks = 0;
  int failures = 0;

  // mode knobs: 0 = low/hold, 1 = high/always, 2 = random
  int          k_req, k_rsp, k_ins;
  logic        k_redir;
  logic [31:0] k_redir_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fire_at(input int i);
    if (i < fire_log.size()) return fire_log[i];
    return 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] pop_pc_at(input int i);
    if (i < pop_log.size()) return pop_log[i].pc;
    return 32'hxxxx_xxxx;
  endfunction

  function automatic logic pick(input int mode);
    if (mode == 2) return 1'($urandom_range(0, 1));
    return mode == 1;
  endfunction

  task automatic step();
    logic exp_rv, exp_iv, fire, pop;
    flight_t f;
    @(negedge clk);
    req_ready      = pick(k_req);
    instr_ready    = pick(k_ins);
    redirect_valid = k_redir;
    redirect_pc    = k_redir_pc;
    if (mem_q.size() != 0 && pick(k_rsp)) begin
      rsp_valid = 1'b1;
      rsp_data  = mem_word(mem_q[0].addr);
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = $urandom;
    end
    #1;
    exp_rv = !k_redir && (fifo.size() + mem_q.size() < DEPTH);
    exp_iv = !k_redir && (fifo.size() != 0);
    chk("req_valid", 32'(req_valid), 32'(exp_rv));
    chk("instr_valid", 32'(instr_valid), 32'(exp_iv));
    chk("busy", 32'(busy), 32'(mem_q.size() != 0));
    if (exp_rv) chk("req_addr", req_addr, m_fetch_pc);
    if (exp_iv) begin
      chk("instr_pc", instr_pc, fifo[0].pc);
      chk("instr_data", instr_data, fifo[0].data);
    end
    fire = exp_rv && req_ready;
    pop  = exp_iv && instr_ready;
    if (k_redir) begin
      if (rsp_valid) void'(mem_q.pop_front());
      epoch++;
      fifo.delete();
      m_fetch_pc = {k_redir_pc[31:2], 2'b00};
    end else begin
      if (pop) begin
        pop_log.push_back('{data: instr_data, pc: instr_pc});
        void'(fifo.pop_front());
      end
      if (rsp_valid) begin
        f = mem_q.pop_front();
        if (f.epoch == epoch) fifo.push_back('{data: mem_word(f.addr), pc: f.addr});
      end
      if (fire) begin
        fire_log.push_back(req_addr);
        mem_q.push_back('{addr: m_fetch_pc, epoch: epoch});
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
  endtask

  task automatic idle_inputs();
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, 32'(req_valid), 32'd0);
    chk({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_instr_data"}, instr_data, 32'd0);
    chk({tag, "_instr_pc"}, instr_pc, 32'd0);
  endtask

  task automatic set_modes(input int r, input int s, input int i);
    k_req = r; k_rsp = s; k_ins = i; k_redir = 1'b0;
  endtask

  task automatic drain();
    set_modes(0, 1, 1);
    repeat (2 * DEPTH + 2) step();
  endtask

  task automatic clear_logs();
    fire_log.delete();
    pop_log.delete();
  endtask

  initial begin
    k_redir_pc = '0;
    set_modes(0, 0, 0);
    epoch = 0;
    m_fetch_pc = PC_INIT;
    rst_n = 1'b0;
    idle_inputs();
    #3;
    check_reset_outputs("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // streaming fetch with 1-cycle memory
    set_modes(1, 1, 1);
    repeat (12) step();
    chk("t1_fire0", fire_at(0), 32'h8000_0000);
    chk("t1_fire1", fire_at(1), 32'h8000_0004);
    chk("t1_fire2", fire_at(2), 32'h8000_0008);
    chk("t1_pop0_pc", pop_pc_at(0), 32'h8000_0000);
    chk("t1_pop0_data", (pop_log.size() > 0) ? pop_log[0].data : 32'hx, 32'hDEAD_3EEF);
    chk("t1_pop1_pc", pop_pc_at(1), 32'h8000_0004);

    // consumer stalled: credit gate stops at DEPTH
    drain();
    clear_logs();
    set_modes(1, 1, 0);
    repeat (10) step();
    chk("t2_fires_full", 32'(fire_log.size()), 32'd4);
    chk("t2_req_blocked", 32'(req_valid), 32'd0);
    k_ins = 1;
    step();
    k_ins = 0;
    repeat (6) step();
    chk("t2_fires_one_more", 32'(fire_log.size()), 32'd5);

    // redirect with two requests in flight
    drain();
    clear_logs();
    set_modes(1, 0, 1);
    repeat (2) step();
    k_redir = 1'b1; k_redir_pc = 32'h8000_0103;
    step();
    k_redir = 1'b0; k_rsp = 1;
    repeat (8) step();
    chk("t3_fire_after_redirect", fire_at(2), 32'h8000_0100);
    chk("t3_first_pop_pc", pop_pc_at(0), 32'h8000_0100);

    // redirect coinciding with the only outstanding response
    drain();
    clear_logs();
    set_modes(1, 0, 1);
    step();
    set_modes(0, 1, 1);
    k_redir = 1'b1; k_redir_pc = 32'h8000_0300;
    step();
    k_redir = 1'b0;
    step();
    chk("t4_busy_clear", 32'(busy), 32'd0);
    chk("t4_queue_empty", 32'(instr_valid), 32'd0);

    // memory stalls: address must hold
    set_modes(0, 0, 1);
    k_redir = 1'b1; k_redir_pc = 32'h8000_0200;
    step();
    k_redir = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_addr_hold", req_addr, 32'h8000_0200);
      chk("t5_valid_hold", 32'(req_valid), 32'd1);
    end
    clear_logs();
    set_modes(1, 1, 1);
    repeat (2) step();
    chk("t5_fire0", fire_at(0), 32'h8000_0200);
    chk("t5_fire1", fire_at(1), 32'h8000_0204);

    // PC wrap, then reset mid-stream
    drain();
    set_modes(0, 1, 1);
    k_redir = 1'b1; k_redir_pc = 32'hFFFF_FFF8;
    step();
    clear_logs();
    set_modes(1, 1, 1);
    repeat (8) step();
    chk("t6_fire0", fire_at(0), 32'hFFFF_FFF8);
    chk("t6_fire1", fire_at(1), 32'hFFFF_FFFC);
    chk("t6_fire2", fire_at(2), 32'h0000_0000);
    chk("t6_pop0_pc", pop_pc_at(0), 32'hFFFF_FFF8);
    chk("t6_pop1_pc", pop_pc_at(1), 32'hFFFF_FFFC);
    chk("t6_pop2_pc", pop_pc_at(2), 32'h0000_0000);
    #2;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check_reset_outputs("midrst");
    mem_q.delete();
    fifo.delete();
    m_fetch_pc = PC_INIT;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    repeat (4) step();
    chk("t6_restart_fire0", fire_at(0), 32'h8000_0000);
    chk("t6_restart_pop0", pop_pc_at(0), 32'h8000_0000);

    // randomized traffic with occasional redirects
    set_modes(2, 2, 2);
    for (int i = 0; i < 3000; i++) begin
      k_redir    = ($urandom_range(0, 15) == 0);
      k_redir_pc = (i % 97 == 0) ? 32'hFFFF_FFF4 : $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
